seq_path_ctrl: RTL and testbench

- Parametrised, job-based beat sequencer for the path/projection datapath.
- Counts accepted input beats from 0 up to a runtime-configurable last value, then wraps to a configurable reload value. The span from 0 to reload is warm-up; reload..last is the steady-state period.
- Emits a one-cycle output-data flag per wrap.
- Adds start/abort control, a per-job flag budget with a done pulse, and configuration checking.
- Sits between the input-valid source and the accumulate/output stage, which consumes cnt and out_data_flag.

---
 rtl/seq_path_ctrl.sv | 138 +++++++++++++
 tb/tb_seq_path_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_path_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : seq_path_ctrl
// Brief    : Job-based beat sequencer with wrap flag, flag budget and abort.
// Revision : 1.0
// ============================================================================
module seq_path_ctrl #(
    parameter int CNT_W = 7,
    parameter int FRM_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] cfg_last,
    input  logic [CNT_W-1:0] cfg_reload,
    input  logic [FRM_W-1:0] cfg_frames,
    input  logic             abort,
    input  logic             in_vld,
    output logic [CNT_W-1:0] cnt,
    output logic             out_data_flag,
    output logic [FRM_W-1:0] flag_idx,
    output logic             busy,
    output logic             done,
    output logic             cfg_err
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t             r_state,    w_state_nxt;
    logic [CNT_W-1:0]   r_cnt,      w_cnt_nxt;
    logic [FRM_W-1:0]   r_flag_idx, w_flag_idx_nxt;
    logic               r_flag,     w_flag_nxt;
    logic               r_done,     w_done_nxt;
    logic               r_cfg_err,  w_cfg_err_nxt;
    logic [CNT_W-1:0]   r_last,     w_last_nxt;
    logic [CNT_W-1:0]   r_reload,   w_reload_nxt;
    logic [FRM_W-1:0]   r_frames,   w_frames_nxt;

    logic               w_cfg_ok;
    logic               w_wrap;
    logic [FRM_W-1:0]   w_idx_inc;

    assign w_cfg_ok  = (cfg_last != '0) && (cfg_reload <= cfg_last);
    assign w_wrap    = (r_cnt == r_last);
    assign w_idx_inc = r_flag_idx + FRM_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_flag_idx <= '0;
            r_flag     <= 1'b0;
            r_done     <= 1'b0;
            r_cfg_err  <= 1'b0;
            r_last     <= '0;
            r_reload   <= '0;
            r_frames   <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_flag_idx <= w_flag_idx_nxt;
            r_flag     <= w_flag_nxt;
            r_done     <= w_done_nxt;
            r_cfg_err  <= w_cfg_err_nxt;
            r_last     <= w_last_nxt;
            r_reload   <= w_reload_nxt;
            r_frames   <= w_frames_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_flag_idx_nxt = r_flag_idx;
        w_flag_nxt     = 1'b0;
        w_done_nxt     = 1'b0;
        w_cfg_err_nxt  = 1'b0;
        w_last_nxt     = r_last;
        w_reload_nxt   = r_reload;
        w_frames_nxt   = r_frames;

        // Abort pre-empts start, beats and any pending wrap flag.
        if (abort) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_cnt_nxt = '0;
                    if (start) begin
                        if (w_cfg_ok) begin
                            w_state_nxt    = S_RUN;
                            w_flag_idx_nxt = '0;
                            w_last_nxt     = cfg_last;
                            w_reload_nxt   = cfg_reload;
                            w_frames_nxt   = cfg_frames;
                        end else begin
                            w_cfg_err_nxt = 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (in_vld) begin
                        if (w_wrap) begin
                            w_cnt_nxt      = r_reload;
                            w_flag_nxt     = 1'b1;
                            w_flag_idx_nxt = w_idx_inc;
                            // Final flag of a bounded job ends it with cnt parked at 0.
                            if ((r_frames != '0) && (w_idx_inc == r_frames)) begin
                                w_done_nxt  = 1'b1;
                                w_state_nxt = S_IDLE;
                                w_cnt_nxt   = '0;
                            end
                        end else begin
                            w_cnt_nxt = r_cnt + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    assign cnt           = r_cnt;
    assign out_data_flag = r_flag;
    assign flag_idx      = r_flag_idx;
    assign busy          = (r_state == S_RUN);
    assign done          = r_done;
    assign cfg_err       = r_cfg_err;

endmodule
`default_nettype wire

// File: tb/tb_seq_path_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_path_ctrl
// Brief    : Directed + randomized bench for seq_path_ctrl against a beat-count model.
// Revision : 1.0
// ============================================================================
module tb_seq_path_ctrl;

    localparam int CNT_W = 7;
    localparam int FRM_W = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic             in_vld = 1'b0;
    logic [CNT_W-1:0] cfg_last = '0;
    logic [CNT_W-1:0] cfg_reload = '0;
    logic [FRM_W-1:0] cfg_frames = '0;
    logic [CNT_W-1:0] cnt;
    logic             out_data_flag;
    logic [FRM_W-1:0] flag_idx;
    logic             busy;
    logic             done;
    logic             cfg_err;

    int vectors = 0;
    int miscompares = 0;

    // Model state: a job is described purely by how many beats it has accepted.
    bit m_run;
    int m_n, m_last, m_reload, m_frames, m_idx;
    bit e_flag, e_done, e_err;

    seq_path_ctrl #(.CNT_W(CNT_W), .FRM_W(FRM_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .cfg_last      (cfg_last),
        .cfg_reload    (cfg_reload),
        .cfg_frames    (cfg_frames),
        .abort         (abort),
        .in_vld        (in_vld),
        .cnt           (cnt),
        .out_data_flag (out_data_flag),
        .flag_idx      (flag_idx),
        .busy          (busy),
        .done          (done),
        .cfg_err       (cfg_err)
    );

    always #5 clk = ~clk;

    function automatic int exp_cnt();
        if (!m_run) return 0;
        if (m_n <= m_last) return m_n;
        return m_reload + (m_n - m_last - 1) % (m_last - m_reload + 1);
    endfunction

    task automatic model_reset();
        m_run = 0; m_n = 0; m_last = 0; m_reload = 0; m_frames = 0; m_idx = 0;
        e_flag = 0; e_done = 0; e_err = 0;
    endtask

    task automatic model_step();
        int period, flags;
        e_flag = 0; e_done = 0; e_err = 0;
        if (abort) begin
            m_run = 0;
        end else if (!m_run) begin
            if (start) begin
                if (cfg_last != 0 && cfg_reload <= cfg_last) begin
                    m_run = 1; m_n = 0; m_idx = 0;
                    m_last = int'(cfg_last); m_reload = int'(cfg_reload);
                    m_frames = int'(cfg_frames);
                end else begin
                    e_err = 1;
                end
            end
        end else if (in_vld) begin
            m_n++;
            period = m_last - m_reload + 1;
            if (m_n >= m_last + 1 && (m_n - m_last - 1) % period == 0) begin
                flags  = (m_n - m_last - 1) / period + 1;
                e_flag = 1;
                m_idx  = flags % 256;
                if (m_frames != 0 && flags == m_frames) begin
                    e_done = 1;
                    m_run  = 0;
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("cnt",      32'(cnt),           32'(exp_cnt()));
        chk("flag",     32'(out_data_flag), 32'(e_flag));
        chk("flag_idx", 32'(flag_idx),      32'(m_idx));
        chk("busy",     32'(busy),          32'(m_run));
        chk("done",     32'(done),          32'(e_done));
        chk("cfg_err",  32'(cfg_err),       32'(e_err));
    endtask

    task automatic drive(input bit s, input bit a, input bit v);
        start = s; abort = a; in_vld = v;
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic set_cfg(input int l, input int r, input int f);
        cfg_last = CNT_W'(l); cfg_reload = CNT_W'(r); cfg_frames = FRM_W'(f);
    endtask

    initial begin
        model_reset();
        #1;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        // Long period, unlimited budget.
        set_cfg(69, 6, 0);
        drive(1, 0, 0);
        repeat (70) drive(0, 0, 1);
        chk("t1_first_cnt", 32'(cnt), 32'd6);
        chk("t1_first_idx", 32'(flag_idx), 32'd1);
        repeat (130) drive(0, 0, 1);
        drive(0, 1, 0);

        // Stall on the wrap index.
        drive(1, 0, 0);
        repeat (69) drive(0, 0, 1);
        chk("t2_at_last", 32'(cnt), 32'd69);
        repeat (5) drive(0, 0, 0);
        drive(0, 0, 1);
        chk("t2_flag", 32'(out_data_flag), 32'd1);
        chk("t2_cnt", 32'(cnt), 32'd6);
        drive(0, 1, 0);

        // Bounded job of three flags.
        set_cfg(3, 1, 3);
        drive(1, 0, 0);
        repeat (10) drive(0, 0, 1);
        chk("t3_done", 32'(done), 32'd1);
        chk("t3_idx", 32'(flag_idx), 32'd3);
        chk("t3_busy", 32'(busy), 32'd0);
        repeat (3) drive(0, 0, 1);

        // Rejected configs and start ignored while running.
        set_cfg(5, 10, 0);
        drive(1, 0, 0);
        chk("t4_err_reload", 32'(cfg_err), 32'd1);
        set_cfg(0, 0, 0);
        drive(1, 0, 0);
        drive(0, 0, 0);
        set_cfg(9, 2, 0);
        drive(1, 0, 0);
        repeat (5) drive(0, 0, 1);
        set_cfg(20, 1, 2);
        drive(1, 0, 1);
        repeat (20) drive(0, 0, 1);
        drive(0, 1, 0);

        // Abort mid-job, abort+start, then clean restart.
        set_cfg(69, 6, 0);
        drive(1, 0, 0);
        repeat (40) drive(0, 0, 1);
        chk("t5_cnt40", 32'(cnt), 32'd40);
        drive(0, 1, 1);
        drive(1, 1, 0);
        chk("t5_busy", 32'(busy), 32'd0);
        drive(1, 0, 0);
        repeat (3) drive(0, 0, 1);

        // Asynchronous reset mid-job.
        drive(0, 1, 0);
        drive(1, 0, 0);
        repeat (50) drive(0, 0, 1);
        chk("t6_cnt50", 32'(cnt), 32'd50);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        set_cfg(4, 2, 2);
        drive(1, 0, 0);
        repeat (12) drive(0, 0, 1);

        // Randomized traffic with config churn.
        repeat (1500) begin
            set_cfg($urandom_range(0, 12), $urandom_range(0, 12), $urandom_range(0, 4));
            drive($urandom_range(0, 9) == 0, $urandom_range(0, 49) == 0,
                  $urandom_range(0, 3) != 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
